// File: rtl/urv_decode_sb.sv
// urv_decode_sb: scoreboarded RV32I/M decode stage (Fetch -> Execute 1).
//
// Decodes the fetched instruction into registered X-stage fields. A per-register
// 3-bit countdown holds how many more edges a multi-cycle producer's result is
// unavailable. A consumer reading a busy register is held as a bubble until its
// operands are free.
//
// Parameters:
//   g_load_latency / g_shift_latency / g_mul_latency : producer latency (1..8)
//   g_with_hw_mul : 0 leaves multiplies undefined and untracked
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   d_stall_i, d_kill_i    downstream freeze, flush of the D->X register
//   d_stall_req_o          hazard present, hold Fetch
//   f_ir_i, f_pc_i, f_valid_i  fetched instruction
//   rf_rs1_o, rf_rs2_o     combinational register-file read addresses
//   x_*                    registered X-stage instruction fields
//   d_stall_count_o        count of issued bubbles
//
// Optional feature: define URV_DECODE_STATS_EN to build the bubble counter.
// Without it, d_stall_count_o is tied to zero.

module urv_decode_sb #(
    parameter int unsigned g_load_latency  = 2,
    parameter int unsigned g_shift_latency = 2,
    parameter int unsigned g_mul_latency   = 2,
    parameter int unsigned g_with_hw_mul   = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        d_stall_i,
    input  logic        d_kill_i,
    output logic        d_stall_req_o,
    input  logic [31:0] f_ir_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_valid_i,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic        x_valid_o,
    output logic [31:0] x_pc_o,
    output logic [31:0] x_ir_o,
    output logic [4:0]  x_rs1_o,
    output logic [4:0]  x_rs2_o,
    output logic [4:0]  x_rd_o,
    output logic [4:0]  x_opcode_o,
    output logic [2:0]  x_fun_o,
    output logic [31:0] x_imm_o,
    output logic        x_rd_write_o,
    output logic        x_is_load_o,
    output logic        x_is_store_o,
    output logic        x_is_undef_o,
    output logic [31:0] d_stall_count_o
);

    localparam logic [4:0] OpcLoad   = 5'b00000;
    localparam logic [4:0] OpcOpImm  = 5'b00100;
    localparam logic [4:0] OpcAuipc  = 5'b00101;
    localparam logic [4:0] OpcStore  = 5'b01000;
    localparam logic [4:0] OpcOp     = 5'b01100;
    localparam logic [4:0] OpcLui    = 5'b01101;
    localparam logic [4:0] OpcBranch = 5'b11000;
    localparam logic [4:0] OpcJalr   = 5'b11001;
    localparam logic [4:0] OpcJal    = 5'b11011;
    localparam logic [4:0] OpcSystem = 5'b11100;

    localparam logic [2:0] FuncAdd = 3'b000;
    localparam logic [2:0] FuncSl  = 3'b001;
    localparam logic [2:0] FuncSr  = 3'b101;

    // Counter load values are latency minus one: the issue edge itself is the
    // first cycle of the producer's latency.
    localparam logic [2:0] LoadInit  = 3'(g_load_latency - 1);
    localparam logic [2:0] ShiftInit = 3'(g_shift_latency - 1);
    localparam logic [2:0] MulInit   = 3'(g_mul_latency - 1);
    localparam bit         HwMul     = (g_with_hw_mul != 0);

    // Fetch-side field decode
    logic [4:0]  f_opcode;
    logic [2:0]  f_fun;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [4:0]  f_rd;
    logic        f_is_shift;
    logic        f_is_mul;
    logic        f_is_undef;
    logic        f_uses_rs2;
    logic        f_writes;
    logic        f_rd_write;
    logic [2:0]  f_fun_x;
    logic [31:0] f_imm;
    logic [2:0]  f_lat_m1;

    assign f_opcode = f_ir_i[6:2];
    assign f_fun    = f_ir_i[14:12];
    assign f_rs1    = f_ir_i[19:15];
    assign f_rs2    = f_ir_i[24:20];
    assign f_rd     = f_ir_i[11:7];

    assign rf_rs1_o = f_rs1;
    assign rf_rs2_o = f_rs2;

    assign f_is_shift = ((f_opcode == OpcOp) || (f_opcode == OpcOpImm)) &&
                        ((f_fun == FuncSl) || (f_fun == FuncSr)) && !f_ir_i[25];
    assign f_is_mul   = (f_opcode == OpcOp) && f_ir_i[25] && !f_fun[2];
    // No divider exists in any configuration, so divides are always undefined.
    assign f_is_undef = (f_opcode == OpcOp) && f_ir_i[25] && (f_fun[2] || !HwMul);
    assign f_uses_rs2 = (f_opcode == OpcOp) || (f_opcode == OpcBranch) ||
                        (f_opcode == OpcStore);

    always_comb begin
        f_writes = 1'b0;
        case (f_opcode)
            OpcOp, OpcOpImm, OpcJal, OpcJalr, OpcLui, OpcAuipc, OpcLoad: f_writes = 1'b1;
            OpcSystem: f_writes = (f_fun != 3'd0);
            default:   f_writes = 1'b0;
        endcase
    end

    assign f_rd_write = f_writes && (f_rd != 5'd0);

    always_comb begin
        f_fun_x = f_fun;
        case (f_opcode)
            OpcJal, OpcJalr, OpcLui, OpcAuipc: f_fun_x = FuncAdd;
            default: f_fun_x = f_fun;
        endcase
    end

    always_comb begin
        f_imm = 32'd0;
        case (f_opcode)
            OpcLoad, OpcOpImm, OpcJalr, OpcSystem:
                f_imm = {{20{f_ir_i[31]}}, f_ir_i[31:20]};
            OpcStore:
                f_imm = {{20{f_ir_i[31]}}, f_ir_i[31:25], f_ir_i[11:7]};
            OpcBranch:
                f_imm = {{20{f_ir_i[31]}}, f_ir_i[7], f_ir_i[30:25], f_ir_i[11:8], 1'b0};
            OpcLui, OpcAuipc:
                f_imm = {f_ir_i[31:12], 12'd0};
            OpcJal:
                f_imm = {{12{f_ir_i[31]}}, f_ir_i[19:12], f_ir_i[20], f_ir_i[30:21], 1'b0};
            default:
                f_imm = 32'd0;
        endcase
    end

    always_comb begin
        f_lat_m1 = 3'd0;
        if (f_opcode == OpcLoad) begin
            f_lat_m1 = LoadInit;
        end else if (f_is_shift) begin
            f_lat_m1 = ShiftInit;
        end else if (f_is_mul && HwMul) begin
            f_lat_m1 = MulInit;
        end
    end

    // Scoreboard
    logic [2:0]  cnt_q [31:1];
    logic [2:0]  cnt_d [31:1];
    logic [31:0] busy;
    logic        hazard;
    logic        issue;

    always_comb begin
        busy[0] = 1'b0;
        for (int i = 1; i < 32; i++) begin
            busy[i] = (cnt_q[i] != 3'd0);
        end
    end

    assign hazard = f_valid_i && !d_kill_i &&
                    (busy[f_rs1] || (f_uses_rs2 && busy[f_rs2]));
    assign issue  = f_valid_i && !d_kill_i && !hazard;

    assign d_stall_req_o = hazard;

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = busy[i] ? (cnt_q[i] - 3'd1) : 3'd0;
            // A new producer never shortens a countdown already in flight.
            if (issue && f_rd_write && (f_lat_m1 != 3'd0) && (f_rd == 5'(i)) &&
                (f_lat_m1 > cnt_d[i])) begin
                cnt_d[i] = f_lat_m1;
            end
        end
    end

    // X-stage registers
    logic        x_valid_q;
    logic [31:0] x_pc_q;
    logic [31:0] x_ir_q;
    logic [2:0]  x_fun_q;
    logic [31:0] x_imm_q;
    logic        x_rd_write_q;
    logic        x_is_load_q;
    logic        x_is_store_q;
    logic        x_is_undef_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_valid_q    <= 1'b0;
            x_pc_q       <= 32'd0;
            x_ir_q       <= 32'd0;
            x_fun_q      <= 3'd0;
            x_imm_q      <= 32'd0;
            x_rd_write_q <= 1'b0;
            x_is_load_q  <= 1'b0;
            x_is_store_q <= 1'b0;
            x_is_undef_q <= 1'b0;
            for (int i = 1; i < 32; i++) begin
                cnt_q[i] <= 3'd0;
            end
        end else if (!d_stall_i) begin
            x_valid_q    <= issue;
            x_pc_q       <= d_kill_i ? 32'd0 : f_pc_i;
            x_ir_q       <= f_ir_i;
            x_fun_q      <= f_fun_x;
            x_imm_q      <= f_imm;
            x_rd_write_q <= f_rd_write;
            x_is_load_q  <= (f_opcode == OpcLoad);
            x_is_store_q <= (f_opcode == OpcStore);
            x_is_undef_q <= f_is_undef;
            for (int i = 1; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign x_valid_o    = x_valid_q;
    assign x_pc_o       = x_pc_q;
    assign x_ir_o       = x_ir_q;
    assign x_rs1_o      = x_ir_q[19:15];
    assign x_rs2_o      = x_ir_q[24:20];
    assign x_rd_o       = x_ir_q[11:7];
    assign x_opcode_o   = x_ir_q[6:2];
    assign x_fun_o      = x_fun_q;
    assign x_imm_o      = x_imm_q;
    assign x_rd_write_o = x_rd_write_q;
    assign x_is_load_o  = x_is_load_q && x_valid_q;
    assign x_is_store_o = x_is_store_q && x_valid_q;
    assign x_is_undef_o = x_is_undef_q;

`ifdef URV_DECODE_STATS_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_count_q <= 32'd0;
        end else if (!d_stall_i && hazard) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign d_stall_count_o = stall_count_q;
`else
    assign d_stall_count_o = 32'd0;
`endif

endmodule

// File: doc/urv_decode_sb.md
# urv_decode_sb

Scoreboarded instruction-decode stage for the uRV core, sitting between Fetch and Execute 1. It decodes RV32I/M instruction fields and immediates into registered X-stage outputs. Unlike the fixed single-bubble decoder, it tracks a per-register pending-write countdown. It inserts as many bubbles as each producer's parametrised latency requires, so load, shift and multiply latencies can change without rewriting hazard logic.

## Interface
- g_load_latency, 2, cycles from X entry until a load result can be forwarded (1..8)
- g_shift_latency, 2, same for shifts (OP/OP_IMM, fun SL/SR, ir[25]=0) (1..8)
- g_mul_latency, 2, same for MUL/MULH* when g_with_hw_mul!=0 (1..8)
- g_with_hw_mul, 0, 0: multiplies are undefined, never tracked
- clk_i  in  1  clock; all logic is rising-edge
- rst_i  in  1  synchronous, active-high reset
- d_stall_i  in  1  pipeline freeze from downstream
- d_kill_i  in  1  flush of the D→X register
- d_stall_req_o  out  1  request to hold Fetch (hazard present)
- f_ir_i  in  32  instruction word
- f_pc_i  in  32  instruction PC
- f_valid_i  in  1  instruction valid
- rf_rs1_o, rf_rs2_o  out  5  combinational f_ir_i[19:15], f_ir_i[24:20]
- x_valid_o  out  1  X-stage instruction valid
- x_pc_o  out  32  PC
- x_ir_o  out  32  raw instruction
- x_rs1_o, x_rs2_o, x_rd_o  out  5  register fields
- x_opcode_o  out  5  ir[6:2]
- x_fun_o  out  3  ir[14:12], forced to FUNC_ADD for JAL/JALR/LUI/AUIPC
- x_imm_o  out  32  decoded immediate (I/S/B/U/J by opcode, 0 otherwise)
- x_rd_write_o  out  1  rd != 0 and opcode writes rd (OP, OP_IMM, JAL, JALR, LUI, AUIPC, LOAD, SYSTEM with fun!=0)
- x_is_load_o, x_is_store_o  out  1  opcode LOAD / STORE and x_valid
- x_is_undef_o  out  1  M-extension op not supported by configuration
- d_stall_count_o  out  32  bubble counter (only with URV_DECODE_STATS_EN)

## Operation
- Scoreboard: 31 counters cnt[1..31], each 3 bits; x0 is never tracked.
- Producer latency L is set by instruction class: load→g_load_latency; shift→g_shift_latency; multiply (hw)→g_mul_latency; otherwise 1. L=1 is untracked.
- Hazard condition: f_valid_i && !d_kill_i && ((cnt[rs1]!=0) || (uses_rs2 && cnt[rs2]!=0)).
  - uses_rs2 holds for OP, BRANCH and STORE.
  - Registers equal to 0 never hazard.
- d_stall_req_o = hazard (combinational).
- On each rising edge with !d_stall_i:
  - If hazard: x_valid_o←0 (bubble). Other X fields are don't-care but still load.
  - Else: x_valid_o←f_valid_i and all X fields load from f_*.
- Every counter decrements by 1 (saturating at 0).
- Issue update: on the same edge, if an issuing instruction (f_valid_i, no hazard, !d_kill_i) has x_rd_write and L>1, then cnt[rd]←max(L-1, cnt[rd]-1).
- d_stall_i=1: all registers and counters hold.
- d_kill_i=1 with !d_stall_i: x_valid_o←0 and x_pc_o←0. Counters still decrement, but no new entry is set. Entries already set for the killed X instruction are kept (conservative).
- Reset: all counters 0, x_valid_o 0, x_pc_o 0, x_ir_o 0, all other X outputs 0, d_stall_count_o 0.

## Timing
- Decode latency is 1 cycle: f_* sampled on edge N appear on X outputs after edge N.
- A dependent instruction directly behind a producer of latency L sees L-1 bubbles. For example, a load followed by a dependent ADD gives 1 bubble with the default latency.
- A dependent instruction k cycles behind sees max(0, L-1-(k-1)) bubbles.
- Bubbles frozen by d_stall_i do not count toward the latency.
- rf_rs*_o are purely combinational, with zero latency.

## Configuration
- Macro URV_DECODE_STATS_EN.
- Defined: d_stall_count_o increments on every edge where !d_stall_i && hazard, wraps modulo 2^32, and clears on reset.
- Undefined: d_stall_count_o is tied to 0 and no counter flops exist.

## Test plan
- Load to x5, then `add x6,x5,x1` back-to-back, defaults → exactly 1 cycle with x_valid_o=0 and d_stall_req_o=1, then the ADD issues.
- g_load_latency=4, load to x7, then dependent `sw x7,0(x2)` → 3 bubbles. An independent instruction inserted between the two reduces this to 2.
- Load to x0, then `add x1,x0,x0` → 0 bubbles. Separately, `lw x3` then `addi x4,x3,1` with d_stall_i held 2 cycles mid-bubble → still 1 issued bubble, and the counter is frozen during the stall.
- g_with_hw_mul=1, g_mul_latency=3: `mul x8` then dependent `sub` → 2 bubbles. With g_with_hw_mul=0: 0 bubbles and x_is_undef_o=1 on the MUL.
- Assert d_kill_i during a hazard bubble → x_valid_o=0, x_pc_o=0, counters keep decrementing, no extra entry is set. Assert rst_i mid-bubble → all counters clear and the next dependent instruction issues with no bubble.
- URV_DECODE_STATS_EN defined: 5 load-use pairs at default latency → d_stall_count_o=5. Undefined → it reads 0.
